// File: rtl/gpp_exec_core_if.sv
// Execute-core bus: instruction issue, write-back report and debug register read.
interface gpp_exec_core_if #(
  parameter int D_WIDTH  = 32,
  parameter int RA_WIDTH = 5
);
  logic [D_WIDTH-1:0]  instr;
  logic                instr_valid;
  logic [RA_WIDTH-1:0] dbg_addr;
  logic [D_WIDTH-1:0]  dbg_data;
  logic                wb_valid;
  logic [RA_WIDTH-1:0] wb_addr;
  logic [D_WIDTH-1:0]  wb_data;
  logic                illegal;

  modport master (
    output instr, instr_valid, dbg_addr,
    input  dbg_data, wb_valid, wb_addr, wb_data, illegal
  );

  modport slave (
    input  instr, instr_valid, dbg_addr,
    output dbg_data, wb_valid, wb_addr, wb_data, illegal
  );
endinterface

// File: rtl/gpp_exec_core.sv
// Single-cycle execute core: decoder, 32-entry register file and ALU for the MIPS-subset GPP.
module gpp_exec_core #(
  parameter int D_WIDTH  = 32,
  parameter int RA_WIDTH = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  gpp_exec_core_if.slave   bus
);
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;

  logic [D_WIDTH-1:0]  regs [2**RA_WIDTH];

  logic [5:0]          op, fn;
  logic [RA_WIDTH-1:0] rs, rt, rd, dest;
  logic [4:0]          sh;
  logic [D_WIDTH-1:0]  imm_ext, alu_a, alu_b, result;
  logic [2:0]          alu_op;
  logic                legal, use_imm, do_write;

  assign op      = bus.instr[31:26];
  assign rs      = bus.instr[25:21];
  assign rt      = bus.instr[20:16];
  assign rd      = bus.instr[15:11];
  assign sh      = bus.instr[10:6];
  assign fn      = bus.instr[5:0];
  assign imm_ext = {{(D_WIDTH-16){1'b0}}, bus.instr[15:0]};

  always_comb begin
    alu_op  = ALU_ADD;
    legal   = 1'b0;
    use_imm = 1'b0;
    dest    = rd;
    if (op == 6'd0) begin
      legal = 1'b1;
      case (fn)
        6'd0:    alu_op = ALU_SHL;
        6'd2:    alu_op = ALU_SHR;
        6'd24:   alu_op = ALU_MUL;
        6'd26:   alu_op = ALU_DIV;
        6'd32:   alu_op = ALU_ADD;
        6'd34:   alu_op = ALU_SUB;
        default: legal  = 1'b0;
      endcase
    end else if (op == 6'd8) begin
      legal   = 1'b1;
      use_imm = 1'b1;
      dest    = rt;
    end
  end

  // Operands come straight from current register state, so a source equal to dest sees the old value.
  assign alu_a = regs[rs];
  assign alu_b = use_imm ? imm_ext : regs[rt];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = alu_a + alu_b;
      ALU_SUB: result = alu_a - alu_b;
      ALU_MUL: result = alu_a * alu_b;
      ALU_DIV: result = (alu_b == '0) ? '1 : alu_a / alu_b;
      ALU_SHL: result = alu_b << sh;
      ALU_SHR: result = alu_b >> sh;
      default: result = '0;
    endcase
  end

  assign do_write = bus.instr_valid && legal;

  // Entry 0 is never written, which keeps it reading as zero.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 2**RA_WIDTH; i++) regs[i] <= '0;
    end else if (do_write && (dest != '0)) begin
      regs[dest] <= result;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bus.wb_valid <= 1'b0;
      bus.wb_addr  <= '0;
      bus.wb_data  <= '0;
      bus.illegal  <= 1'b0;
    end else begin
      bus.wb_valid <= do_write;
      bus.illegal  <= bus.instr_valid && !legal;
      if (do_write) begin
        bus.wb_addr <= dest;
        bus.wb_data <= result;
      end
    end
  end

  assign bus.dbg_data = regs[bus.dbg_addr];
endmodule

// File: tb/tb_gpp_exec_core.sv
// Scoreboard bench for gpp_exec_core: expected write-back reports are queued at issue and checked after each edge.
`timescale 1ns/10ps
module tb_gpp_exec_core;
  logic Clk;
  logic Rst;

  gpp_exec_core_if #(.D_WIDTH(32), .RA_WIDTH(5)) bus ();

  gpp_exec_core #(.D_WIDTH(32), .RA_WIDTH(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [4:0]  hold_addr = '0;
  logic [31:0] hold_data = '0;

  // Monitor: one queued expectation per clock edge.
  always begin
    @(posedge Clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({bus.wb_valid, bus.wb_addr, bus.wb_data, bus.illegal} !== {e.v, e.a, e.d, e.ill}) begin
        failures++;
        $display("FAIL wb_report: got v=%b a=%0d d=%h ill=%b, expected v=%b a=%0d d=%h ill=%b",
                 bus.wb_valid, bus.wb_addr, bus.wb_data, bus.illegal, e.v, e.a, e.d, e.ill);
      end
    end
  end

  task automatic exec(input logic [31:0] ins, input logic ev, input logic [4:0] ea,
                      input logic [31:0] ed, input logic eill);
    exp_t e;
    @(negedge Clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    if (ev) begin
      hold_addr = ea;
      hold_data = ed;
    end
    e.v = ev; e.a = hold_addr; e.d = hold_data; e.ill = eill;
    sb.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      bus.instr_valid = 1'b0;
      e.v = 1'b0; e.a = hold_addr; e.d = hold_data; e.ill = 1'b0;
      sb.push_back(e);
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic check_reg(input logic [4:0] addr, input logic [31:0] exp_val);
    bus.dbg_addr = addr;
    #0.1;
    checks++;
    if (bus.dbg_data !== exp_val) begin
      failures++;
      $display("FAIL dbg_r%0d: got %h, expected %h", addr, bus.dbg_data, exp_val);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({bus.wb_valid, bus.wb_addr, bus.wb_data, bus.illegal} !== '0) begin
      failures++;
      $display("FAIL %s_outputs: got v=%b a=%0d d=%h ill=%b, expected all 0",
               tag, bus.wb_valid, bus.wb_addr, bus.wb_data, bus.illegal);
    end
    for (int r = 0; r < 32; r++) check_reg(5'(r), 32'h0);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.dbg_addr = '0;
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_addi();
    exec(32'h20010005, 1'b1, 5'd1, 32'h00000005, 1'b0);
    exec(32'h2002FFFF, 1'b1, 5'd2, 32'h0000FFFF, 1'b0);
    check_reg(5'd1, 32'h00000005);
    check_reg(5'd2, 32'h0000FFFF);
  endtask

  task automatic test_add_sub();
    exec(32'h00221820, 1'b1, 5'd3, 32'h00010004, 1'b0);
    exec(32'h00222022, 1'b1, 5'd4, 32'hFFFF0006, 1'b0);
    check_reg(5'd3, 32'h00010004);
    check_reg(5'd4, 32'hFFFF0006);
  endtask

  task automatic test_shift();
    exec(32'h00012900, 1'b1, 5'd5, 32'h00000050, 1'b0);
    exec(32'h00023202, 1'b1, 5'd6, 32'h000000FF, 1'b0);
    check_reg(5'd5, 32'h00000050);
    check_reg(5'd6, 32'h000000FF);
  endtask

  task automatic test_mul_div();
    exec(32'h00423818, 1'b1, 5'd7, 32'hFFFE0001, 1'b0);
    exec(32'h0041401A, 1'b1, 5'd8, 32'h00003333, 1'b0);
    exec(32'h0020481A, 1'b1, 5'd9, 32'hFFFFFFFF, 1'b0);
    idle(1);
    check_reg(5'd7, 32'hFFFE0001);
    check_reg(5'd8, 32'h00003333);
    check_reg(5'd9, 32'hFFFFFFFF);
  endtask

  task automatic test_r0_write();
    exec(32'h20200001, 1'b1, 5'd0, 32'h00000006, 1'b0);
    check_reg(5'd0, 32'h00000000);
    // Carry out of ADD is discarded: 0xFFFFFFFF + 5 = 4.
    exec(32'h01216020, 1'b1, 5'd12, 32'h00000004, 1'b0);
    check_reg(5'd12, 32'h00000004);
  endtask

  task automatic test_illegal();
    exec(32'hFC000000, 1'b0, 5'd0, 32'h0, 1'b1);
    idle(1);
    exec(32'h00000001, 1'b0, 5'd0, 32'h0, 1'b1);
    idle(2);
    check_reg(5'd0, 32'h00000000);
    check_reg(5'd1, 32'h00000005);
    check_reg(5'd12, 32'h00000004);
  endtask

  task automatic test_back_to_back();
    exec(32'h200A0003, 1'b1, 5'd10, 32'h00000003, 1'b0);
    exec(32'h014A5020, 1'b1, 5'd10, 32'h00000006, 1'b0);
    exec(32'h01435822, 1'b1, 5'd11, 32'hFFFF0002, 1'b0);
    exec(32'hFC000000, 1'b0, 5'd0, 32'h0, 1'b1);
    exec(32'h20010005, 1'b1, 5'd1, 32'h00000005, 1'b0);
    idle(1);
    check_reg(5'd10, 32'h00000006);
    check_reg(5'd11, 32'hFFFF0002);
  endtask

  task automatic test_async_reset();
    idle(1);
    Rst = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    #0.5;
    check_all_zero("async_reset");
    @(negedge Clk);
    Rst = 1'b1;
    idle(3);
    check_reg(5'd1, 32'h0);
    check_reg(5'd4, 32'h0);
  endtask

  task automatic test_reset_discard();
    @(negedge Clk);
    bus.instr       = 32'h20010005;
    bus.instr_valid = 1'b1;
    #2;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    idle(2);
    check_reg(5'd1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_add_sub();
    test_shift();
    test_mul_div();
    test_r0_write();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_reset_discard();
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpp_exec_core.md
Name: gpp_exec_core

Overview:
- Single-cycle execute datapath of the 32-bit MIPS-subset GPP, combining the instruction decoder, the 32x32 register file and the ALU.
- Accepts one 32-bit instruction word per clock when valid.
- Decodes the instruction, reads operands, computes the result and writes it back at the same rising edge.
- Exposes a registered write-back report plus a combinational debug read port for the controller/testbench.

Parameters:
- D_WIDTH, 32, data/instruction width
- RA_WIDTH, 5, register address width (2^RA_WIDTH registers)

Ports:
- Clk  in  1  clock, rising-edge active
- Rst  in  1  asynchronous reset, active-low
- instr  in  D_WIDTH  instruction word
- instr_valid  in  1  execute instr at this rising edge
- dbg_addr  in  RA_WIDTH  debug read address
- dbg_data  out  D_WIDTH  combinational contents of register dbg_addr
- wb_valid  out  1  registered; a write-back occurred at the previous edge
- wb_addr  out  RA_WIDTH  registered destination of that write
- wb_data  out  D_WIDTH  registered value written
- illegal  out  1  registered; previous valid instruction was unsupported

Behaviour:
- Reset (Rst=0, asynchronous): all 32 registers become 0; wb_valid, wb_addr, wb_data and illegal become 0. Reset mid-operation discards the in-flight instruction.
- Decode fields:
  - op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0]
  - imm=instr[15:0], zero-extended to 32 bits
- Supported instructions (all arithmetic unsigned, modulo 2^32):
  - op=0, fn=0 (SLL): R[rd] = R[rt] << sh (logical)
  - op=0, fn=2 (SRL): R[rd] = R[rt] >> sh (logical, zero fill)
  - op=0, fn=24 (MUL): R[rd] = low 32 bits of R[rs]*R[rt]
  - op=0, fn=26 (DIV): R[rd] = R[rs]/R[rt] truncated; divisor 0 gives 0xFFFFFFFF
  - op=0, fn=32 (ADD): R[rd] = R[rs]+R[rt]; carry discarded
  - op=0, fn=34 (SUB): R[rd] = R[rs]-R[rt]; wraps
  - op=8 (ADDI): R[rt] = R[rs]+imm
- ALU op encoding (internal): 000 add, 001 sub, 010 mul, 011 div, 100 shl, 101 shr. Any other code yields 0.
- Register 0 is hardwired to 0. Writes to it are dropped; wb_valid still pulses with wb_addr=0 and wb_data equal to the computed value.
- Operand reads are combinational from current register state. Write happens at the rising edge where instr_valid=1 (single-cycle latency). The new value is visible on dbg_data and to the next instruction immediately after that edge.
- Same register as source and destination: the old value is used and the new value is written.
- Registered outputs at the edge:
  - Supported instruction: wb_valid=1, wb_addr=destination, wb_data=result, illegal=0.
  - Unsupported op/fn: no register write, wb_valid=0, illegal=1.
  - instr_valid=0: wb_valid=0, illegal=0, registers unchanged.
- Back-to-back valid instructions are allowed every cycle with no stall.
- Outputs hold wb_addr/wb_data until the next valid supported instruction; only wb_valid and illegal are pulses.

Test Plan:
- Reset, then ADDI r1=r0+0x0005 (0x20010005), ADDI r2=r0+0xFFFF (0x2002FFFF) -> dbg r1=5, r2=0x0000FFFF; wb_valid pulses with wb_addr=1 then 2.
- ADD r3=r1+r2 (0x00221820) then SUB r4=r1-r2 (0x00222022) -> r3=0x00010004, r4=0xFFFF0006.
- SLL r5=r1<<4 (0x00012900) and SRL r6=r2>>8 (0x00023202) -> r5=0x50, r6=0xFF.
- MUL r7=r2*r2 (0x00423818) -> r7=0xFFFE0001. DIV r8=r2/r1 (0x0041401A) -> 0x3333. DIV r9=r1/r0 -> 0xFFFFFFFF.
- Write to r0 via ADDI r0=r1+1 -> wb_valid=1, wb_addr=0, wb_data=6, r0 reads 0. Unsupported op=0x3F -> illegal=1 for one cycle, wb_valid=0, no register changes.
- Assert Rst low asynchronously between edges after the above -> all registers and outputs 0 immediately; instr_valid=0 for several cycles leaves state unchanged.
